vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Consumes the pixel-timing outputs of the VGA timing generator: hsync, vsync, valid, h_cnt, v_cnt.
- Generates read addresses into the camera frame buffer (dual-port BRAM, RGB444) and replicates each stored pixel 2^SCALE_SHIFT times horizontally and vertically.
- Realigns hsync, vsync and valid with the returned pixel data and drives the registered RGB/sync outputs to the VGA connector.
- Pixels outside the stored image window show BORDER_COLOR.

Parameters:
- IMG_W, 320, stored image width in pixels.
- IMG_H, 240, stored image height in lines.
- SCALE_SHIFT, 1, log2 of the replication factor (0 = 1x, 1 = 2x, 2 = 4x).
- ADDR_W, 17, frame-buffer address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W.
- RD_LAT, 2, frame-buffer read latency in cycles (1..4).
- BORDER_COLOR, 12'h000, RGB444 value shown outside the window.
- VSYNC_ACTIVE, 1'b0, active level of the incoming vsync.

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hsync  in  1  timing hsync
- vsync  in  1  timing vsync
- valid  in  1  timing active-video flag
- h_cnt  in  11  timing pixel column (0 outside active video)
- v_cnt  in  10  timing line (informational only; not used for addressing)
- rd_addr  out  ADDR_W  frame-buffer read address
- rd_en  out  1  frame-buffer read enable
- rd_data  in  12  frame-buffer data, {R[3:0],G[3:0],B[3:0]}, valid RD_LAT cycles after rd_addr/rd_en
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hsync  out  1  delayed hsync
- vga_vsync  out  1  delayed vsync
- sof  out  1  one-cycle start-of-frame pulse

Behaviour:
- Reset (asynchronous, active-high; clears all registers):
  - rd_addr = 0, rd_en = 0, RGB = 0, sof = 0.
  - vga_hsync and vga_vsync = 1, and every stage of the sync delay lines = 1.
  - line_base = 0, rep_cnt = 0, row_idx = 0, valid_d = 0, vsync_d = ~VSYNC_ACTIVE.
- Frame start (FS):
  - Condition: vsync == VSYNC_ACTIVE and vsync_d != VSYNC_ACTIVE.
  - Action: line_base <= 0, rep_cnt <= 0, row_idx <= 0, sof <= 1 for exactly one cycle.
- End of line (EOL):
  - Condition: valid_d == 1 and valid == 0.
  - If rep_cnt == 2^SCALE_SHIFT-1: rep_cnt <= 0, row_idx <= row_idx+1, line_base <= line_base+IMG_W.
  - Otherwise: rep_cnt <= rep_cnt+1.
  - row_idx saturates at IMG_H; line_base does not advance once row_idx == IMG_H.
- FS and EOL in the same cycle: FS wins and EOL is discarded.
- Window: in_win = valid && (h_cnt >> SCALE_SHIFT) < IMG_W && row_idx < IMG_H.
- Stage 1 (registered, 1 cycle after inputs):
  - rd_en <= in_win.
  - rd_addr <= in_win ? line_base + (h_cnt >> SCALE_SHIFT) : rd_addr (holds its last value).
  - Arithmetic is done at ADDR_W bits; there is no wrap, because the parameter constraint guarantees range.
- Delay lines: hsync, vsync, valid and in_win are each delayed RD_LAT+1 cycles to align with rd_data.
- Output stage (registered):
  - RGB <= delayed in_win ? rd_data : (delayed valid ? BORDER_COLOR : 12'h000).
  - vga_hsync and vga_vsync are taken from the final delay-line stage.
- Total latency from inputs to all outputs: RD_LAT+2 cycles. Syncs, valid and colour stay mutually aligned.
- Blanking: RGB is forced to 0 whenever the delayed valid is 0, as the DAC requires.
- Reset asserted mid-frame:
  - All outputs immediately return to their reset values.
  - After deassertion, addressing restarts at the next FS. Until then line_base = 0, so a partial frame reads from the top of the image.
- Addressing uses h_cnt and valid only. v_cnt is ignored, because a 0 on v_cnt is ambiguous outside active video.

Test Plan:
1. Defaults, 640x480 timing, frame buffer preloaded with mem[a] = a[11:0]. After FS, first active pixel -> rd_addr = 0. Pixel h = 2,3 -> addr 1. Line 1 -> addr 0..319 again. Line 2 -> first addr 320. RGB appears RD_LAT+2 = 4 cycles after the inputs.
2. Sync alignment: vga_hsync equals hsync delayed exactly 4 cycles; vga_vsync likewise; RGB = 0 throughout blanking.
3. IMG_W = 200, IMG_H = 100, SCALE_SHIFT = 1 -> columns 400..639 show BORDER_COLOR = 12'hF00, rd_en = 0 there. Lines 200..479 show border. Last valid addr = 19999.
4. Frame wrap: after line 479, FS on the next vsync assertion -> sof pulses for 1 cycle and the first active pixel reads addr 0 again. Also force FS and EOL in the same cycle -> line_base = 0, rep_cnt = 0.
5. Assert reset for 3 cycles mid-line at line 100 -> all outputs at reset values during reset. rd_addr restarts at 0 from the next line onward; the correct sequence resumes after the following FS.
6. RD_LAT = 1 and RD_LAT = 4 variants -> total latency 3 and 6 cycles respectively, with data/sync alignment preserved.

Source files
------------

// File: rtl/vga_frame_reader.sv
// VGA frame-buffer reader: scaled read-address generation, BRAM latency
// realignment of sync/valid, and registered RGB/sync outputs.
module vga_frame_reader #(
    parameter int          IMG_W        = 320,
    parameter int          IMG_H        = 240,
    parameter int          SCALE_SHIFT  = 1,
    parameter int          ADDR_W       = 17,
    parameter int          RD_LAT       = 2,
    parameter logic [11:0] BORDER_COLOR = 12'h000,
    parameter logic        VSYNC_ACTIVE = 1'b0
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              valid,
    input  logic [10:0]       h_cnt,
    input  logic [9:0]        v_cnt,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [11:0]       rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              sof
);
    localparam int REP_W = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int DL    = RD_LAT + 1;

    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(IMG_H);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);
    localparam logic [10:0]       COL_LIM   = 11'(IMG_W);

    logic              r_vsync_d;
    logic              r_valid_d;
    logic [ADDR_W-1:0] r_line_base;
    logic [REP_W-1:0]  r_rep_cnt;
    logic [ROW_W-1:0]  r_row_idx;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_sof;
    logic [DL-1:0]     r_hs_dl;
    logic [DL-1:0]     r_vs_dl;
    logic [DL-1:0]     r_vld_dl;
    logic [DL-1:0]     r_win_dl;
    logic [11:0]       r_rgb;
    logic              r_hs_o;
    logic              r_vs_o;

    logic              w_fs;
    logic              w_eol;
    logic              w_in_win;
    logic [10:0]       w_col;
    logic              w_unused;

    // v_cnt is ambiguous outside active video, so lines are counted instead
    assign w_unused = ^v_cnt;

    assign w_col    = h_cnt >> SCALE_SHIFT;
    assign w_fs     = (vsync == VSYNC_ACTIVE) && (r_vsync_d != VSYNC_ACTIVE);
    assign w_eol    = r_valid_d && !valid;
    assign w_in_win = valid && (w_col < COL_LIM) && (r_row_idx < ROW_MAX);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_vsync_d   <= ~VSYNC_ACTIVE;
            r_valid_d   <= 1'b0;
            r_sof       <= 1'b0;
            r_line_base <= '0;
            r_rep_cnt   <= '0;
            r_row_idx   <= '0;
        end else begin
            r_vsync_d <= vsync;
            r_valid_d <= valid;
            r_sof     <= w_fs;
            if (w_fs) begin
                r_line_base <= '0;
                r_rep_cnt   <= '0;
                r_row_idx   <= '0;
            end else if (w_eol) begin
                if (r_rep_cnt == REP_MAX) begin
                    r_rep_cnt <= '0;
                    if (r_row_idx < ROW_MAX) begin
                        r_row_idx   <= r_row_idx + 1'b1;
                        r_line_base <= r_line_base + LINE_STEP;
                    end
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end
    end

    // Read request plus RD_LAT+1 delay lines so output sees matching data
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_hs_dl   <= '1;
            r_vs_dl   <= '1;
            r_vld_dl  <= '0;
            r_win_dl  <= '0;
            r_rgb     <= 12'h000;
            r_hs_o    <= 1'b1;
            r_vs_o    <= 1'b1;
        end else begin
            r_rd_en <= w_in_win;
            if (w_in_win) begin
                r_rd_addr <= r_line_base + ADDR_W'(w_col);
            end
            r_hs_dl  <= {r_hs_dl[DL-2:0], hsync};
            r_vs_dl  <= {r_vs_dl[DL-2:0], vsync};
            r_vld_dl <= {r_vld_dl[DL-2:0], valid};
            r_win_dl <= {r_win_dl[DL-2:0], w_in_win};
            if (r_win_dl[DL-1]) begin
                r_rgb <= rd_data;
            end else if (r_vld_dl[DL-1]) begin
                r_rgb <= BORDER_COLOR;
            end else begin
                r_rgb <= 12'h000;
            end
            r_hs_o <= r_hs_dl[DL-1];
            r_vs_o <= r_vs_dl[DL-1];
        end
    end

    assign rd_addr   = r_rd_addr;
    assign rd_en     = r_rd_en;
    assign sof       = r_sof;
    assign vga_r     = r_rgb[11:8];
    assign vga_g     = r_rgb[7:4];
    assign vga_b     = r_rgb[3:0];
    assign vga_hsync = r_hs_o;
    assign vga_vsync = r_vs_o;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: three parameter variants driven by one
// timing stream, checked against a line-counting reference model.
module tb_vga_frame_reader;
    localparam int          NDUT = 3;
    localparam int          MAXC = 40000;
    localparam int          PW[NDUT]   = '{16, 10, 24};
    localparam int          PH[NDUT]   = '{8, 6, 12};
    localparam int          PS[NDUT]   = '{1, 2, 0};
    localparam int          PLAT[NDUT] = '{2, 4, 1};
    localparam logic [11:0] PB[NDUT]   = '{12'h123, 12'hF00, 12'h0F0};
    localparam logic        PV[NDUT]   = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        valid = 1'b0;
    logic [10:0] h_cnt = '0;
    logic [9:0]  v_cnt = '0;

    logic [9:0]  a_addr;
    logic [7:0]  b_addr;
    logic [8:0]  c_addr;
    logic        a_en, b_en, c_en;
    logic [11:0] a_rd, b_rd, c_rd;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic        a_hs, a_vs, a_sof, b_hs, b_vs, b_sof, c_hs, c_vs, c_sof;

    always #5 clk = ~clk;

    vga_frame_reader #(.IMG_W(PW[0]), .IMG_H(PH[0]), .SCALE_SHIFT(PS[0]),
        .ADDR_W(10), .RD_LAT(PLAT[0]), .BORDER_COLOR(PB[0]),
        .VSYNC_ACTIVE(PV[0])) u_a (
        .pclk(clk), .reset(rst), .hsync(hsync), .vsync(vsync),
        .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt), .rd_addr(a_addr),
        .rd_en(a_en), .rd_data(a_rd), .vga_r(a_r), .vga_g(a_g),
        .vga_b(a_b), .vga_hsync(a_hs), .vga_vsync(a_vs), .sof(a_sof));

    vga_frame_reader #(.IMG_W(PW[1]), .IMG_H(PH[1]), .SCALE_SHIFT(PS[1]),
        .ADDR_W(8), .RD_LAT(PLAT[1]), .BORDER_COLOR(PB[1]),
        .VSYNC_ACTIVE(PV[1])) u_b (
        .pclk(clk), .reset(rst), .hsync(hsync), .vsync(vsync),
        .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt), .rd_addr(b_addr),
        .rd_en(b_en), .rd_data(b_rd), .vga_r(b_r), .vga_g(b_g),
        .vga_b(b_b), .vga_hsync(b_hs), .vga_vsync(b_vs), .sof(b_sof));

    vga_frame_reader #(.IMG_W(PW[2]), .IMG_H(PH[2]), .SCALE_SHIFT(PS[2]),
        .ADDR_W(9), .RD_LAT(PLAT[2]), .BORDER_COLOR(PB[2]),
        .VSYNC_ACTIVE(PV[2])) u_c (
        .pclk(clk), .reset(rst), .hsync(hsync), .vsync(vsync),
        .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt), .rd_addr(c_addr),
        .rd_en(c_en), .rd_data(c_rd), .vga_r(c_r), .vga_g(c_g),
        .vga_b(c_b), .vga_hsync(c_hs), .vga_vsync(c_vs), .sof(c_sof));

    // Frame-buffer contents: odd multiplier keeps every address distinct
    function automatic logic [11:0] memf(input int d, input int a);
        int v;
        v = a * 29 + d * 7 + 11;
        return v[11:0];
    endfunction

    logic [11:0] pa[4], pb[4], pc[4];
    always @(posedge clk) begin
        pa[0] <= memf(0, 32'(a_addr));
        pb[0] <= memf(1, 32'(b_addr));
        pc[0] <= memf(2, 32'(c_addr));
        for (int k = 1; k < 4; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
            pc[k] <= pc[k-1];
        end
    end
    assign a_rd = pa[PLAT[0]-1];
    assign b_rd = pb[PLAT[1]-1];
    assign c_rd = pc[PLAT[2]-1];

    logic [11:0] o_rgb[NDUT];
    logic        o_hs[NDUT], o_vs[NDUT], o_en[NDUT], o_sof[NDUT];
    int          o_addr[NDUT];
    always_comb begin
        o_rgb[0] = {a_r, a_g, a_b};
        o_rgb[1] = {b_r, b_g, b_b};
        o_rgb[2] = {c_r, c_g, c_b};
        o_hs = '{a_hs, b_hs, c_hs};
        o_vs = '{a_vs, b_vs, c_vs};
        o_en = '{a_en, b_en, c_en};
        o_sof = '{a_sof, b_sof, c_sof};
        o_addr[0] = 32'(a_addr);
        o_addr[1] = 32'(b_addr);
        o_addr[2] = 32'(c_addr);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: counts active lines since frame start
    int          lines[NDUT];
    logic        pvld[NDUT], pvs[NDUT];
    int          e_addr[NDUT];
    logic        e_en[NDUT], e_sof[NDUT];
    logic [13:0] hist[NDUT][MAXC];
    int          cnt;

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            lines[d] = 0;
            pvld[d] = 1'b0;
            pvs[d] = ~PV[d];
            e_addr[d] = 0;
            e_en[d] = 1'b0;
            e_sof[d] = 1'b0;
        end
        cnt = 0;
    endtask

    task automatic model_step();
        int row, col;
        logic fs, eol, win;
        logic [11:0] pix;
        for (int d = 0; d < NDUT; d++) begin
            fs = (vsync == PV[d]) && (pvs[d] != PV[d]);
            eol = pvld[d] && !valid;
            row = lines[d] >> PS[d];
            if (row > PH[d]) row = PH[d];
            col = int'(h_cnt) >> PS[d];
            win = valid && col < PW[d] && row < PH[d];
            if (win) e_addr[d] = row * PW[d] + col;
            e_en[d] = win;
            e_sof[d] = fs;
            pix = win ? memf(d, row * PW[d] + col) : (valid ? PB[d] : 12'h000);
            hist[d][cnt] = {hsync, vsync, pix};
            if (fs) lines[d] = 0;
            else if (eol) lines[d]++;
            pvld[d] = valid;
            pvs[d] = vsync;
        end
    endtask

    task automatic check_all();
        logic [13:0] ex;
        for (int d = 0; d < NDUT; d++) begin
            ex = (cnt >= PLAT[d] + 1) ? hist[d][cnt-PLAT[d]-1] : 14'h3000;
            chk($sformatf("rgb%0d", d), int'(o_rgb[d]), int'(ex[11:0]));
            chk($sformatf("hsync%0d", d), int'(o_hs[d]), int'(ex[13]));
            chk($sformatf("vsync%0d", d), int'(o_vs[d]), int'(ex[12]));
            chk($sformatf("rd_en%0d", d), int'(o_en[d]), int'(e_en[d]));
            chk($sformatf("rd_addr%0d", d), o_addr[d], e_addr[d]);
            chk($sformatf("sof%0d", d), int'(o_sof[d]), int'(e_sof[d]));
        end
    endtask

    task automatic cyc(input logic hs_i, input logic vs_i,
                       input logic vld_i, input int hc_i);
        hsync = hs_i;
        vsync = vs_i;
        valid = vld_i;
        h_cnt = 11'(hc_i);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (cnt < MAXC) check_all();
        cnt++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_rgb%0d", d), int'(o_rgb[d]), 0);
            chk($sformatf("rst_hs%0d", d), int'(o_hs[d]), 1);
            chk($sformatf("rst_vs%0d", d), int'(o_vs[d]), 1);
            chk($sformatf("rst_en%0d", d), int'(o_en[d]), 0);
            chk($sformatf("rst_addr%0d", d), o_addr[d], 0);
            chk($sformatf("rst_sof%0d", d), int'(o_sof[d]), 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic frame(input int rst_line);
        int ha, va, ht, vt;
        logic vld, hs, vs;
        ha = $urandom_range(52, 28);
        va = $urandom_range(34, 14);
        ht = ha + 6;
        vt = va + 5;
        for (int ln = 0; ln < vt; ln++) begin
            v_cnt = (ln < va) ? 10'(ln) : 10'd0;
            for (int x = 0; x < ht; x++) begin
                vld = (ln < va) && (x < ha);
                hs = !(x >= ha + 1 && x < ha + 3);
                vs = !(ln >= va + 1 && ln < va + 3);
                cyc(hs, vs, vld, vld ? x : 0);
                if (ln == rst_line && x == 7) apply_reset();
            end
        end
    endtask

    typedef struct {
        logic vs;
        logic vld;
        int   h;
        logic sof;
        logic en;
        int   addr;
    } vec_t;

    vec_t tv[15];

    initial begin
        tv[0]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 0};
        tv[1]  = '{1'b1, 1'b1, 0,  1'b0, 1'b1, 0};
        tv[2]  = '{1'b1, 1'b1, 3,  1'b0, 1'b1, 1};
        tv[3]  = '{1'b1, 1'b1, 31, 1'b0, 1'b1, 15};
        tv[4]  = '{1'b1, 1'b1, 32, 1'b0, 1'b0, 15};
        tv[5]  = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 15};
        tv[6]  = '{1'b1, 1'b1, 2,  1'b0, 1'b1, 1};
        tv[7]  = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 1};
        tv[8]  = '{1'b1, 1'b1, 4,  1'b0, 1'b1, 18};
        tv[9]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 18};
        tv[10] = '{1'b0, 1'b1, 0,  1'b0, 1'b1, 0};
        tv[11] = '{1'b0, 1'b0, 0,  1'b0, 1'b0, 0};
        tv[12] = '{1'b0, 1'b1, 6,  1'b0, 1'b1, 3};
        tv[13] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 3};
        tv[14] = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 16};

        #3;
        apply_reset();

        // Directed addressing on the 2x variant, including FS+EOL together
        for (int i = 0; i < 15; i++) begin
            hsync = 1'b1;
            vsync = tv[i].vs;
            valid = tv[i].vld;
            h_cnt = 11'(tv[i].h);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_sof", i), int'(a_sof), int'(tv[i].sof));
            chk($sformatf("vec%0d_en", i), int'(a_en), int'(tv[i].en));
            chk($sformatf("vec%0d_addr", i), int'(a_addr), tv[i].addr);
        end

        apply_reset();
        for (int f = 0; f < 6; f++) frame(f == 2 ? 9 : -1);

        for (int i = 0; i < 1500; i++) begin
            logic v;
            v = ($urandom % 4) != 0;
            cyc(1'($urandom), ($urandom % 8) != 0, v, v ? int'($urandom % 64) : 0);
        end

        for (int f = 0; f < 2; f++) frame(-1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
